// File: rtl/sram_port_arbiter_pkg.sv
// Shared definitions for the IF/MEM SRAM port arbiter.
//   OWNER_*  : who owns the read data returning this cycle
//   WORD_W   : native word width of the instruction/data SRAM
//   SEL_W    : byte-enable width of the SRAM write port
//   CNT_W    : width of the IF starvation counter
//   REQ_*    : index of each requester in the per-requester arrays
package sram_port_arbiter_pkg;
   localparam int WORD_W  = 32;
   localparam int SEL_W   = 4;
   localparam int CNT_W   = 4;
   localparam int NUM_REQ = 2;
   localparam int REQ_IF  = 0;
   localparam int REQ_MEM = 1;

   typedef enum logic [1:0] {
      OWNER_NONE   = 2'd0,
      OWNER_IF     = 2'd1,
      OWNER_MEM_RD = 2'd2
   } owner_e;
endpackage

// File: rtl/sram_port_arbiter_if.sv
// Bus bundle between the pipeline (IF/MEM requesters), the arbiter and the SRAM.
//   slave  : arbiter view (requests and sram_rdata in; grants, returns, stalls, SRAM drive out)
//   master : environment view (pipeline + SRAM), the mirror image
interface sram_port_arbiter_if
   import sram_port_arbiter_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = WORD_W
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_rvalid;
   logic [DATA_W-1:0] if_rdata;

   logic              mem_req;
   logic              mem_we;
   logic [SEL_W-1:0]  mem_sel;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_gnt;
   logic              mem_rvalid;
   logic [DATA_W-1:0] mem_rdata;

   logic              stall_if_o;
   logic              stall_mem_o;

   logic              sram_en;
   logic [SEL_W-1:0]  sram_wen;
   logic [ADDR_W-1:0] sram_addr;
   logic [DATA_W-1:0] sram_wdata;
   logic [DATA_W-1:0] sram_rdata;

   modport slave (
      input  if_req, if_addr,
      input  mem_req, mem_we, mem_sel, mem_addr, mem_wdata,
      input  sram_rdata,
      output if_gnt, if_rvalid, if_rdata,
      output mem_gnt, mem_rvalid, mem_rdata,
      output stall_if_o, stall_mem_o,
      output sram_en, sram_wen, sram_addr, sram_wdata
   );

   modport master (
      output if_req, if_addr,
      output mem_req, mem_we, mem_sel, mem_addr, mem_wdata,
      output sram_rdata,
      input  if_gnt, if_rvalid, if_rdata,
      input  mem_gnt, mem_rvalid, mem_rdata,
      input  stall_if_o, stall_mem_o,
      input  sram_en, sram_wen, sram_addr, sram_wdata
   );
endinterface

// File: rtl/sram_port_arbiter_rdata_hold.sv
// Per-requester read-return path: when this requester owns the returning
// read, the SRAM data is bypassed straight out and captured; otherwise the
// last captured word is presented so the pipeline sees stable data.
//   clk, rst      : clock, async active-low reset
//   ret_i         : this requester owns the data on sram_rdata_i this cycle
//   sram_rdata_i  : SRAM read data
//   rvalid_o      : read data valid
//   rdata_o       : bypassed or held read data
module sram_port_arbiter_rdata_hold #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ret_i,
   input  logic [DATA_W-1:0] sram_rdata_i,
   output logic              rvalid_o,
   output logic [DATA_W-1:0] rdata_o
);
   logic [DATA_W-1:0] hold_q, hold_d;

   always_comb begin
      hold_d = hold_q;
      if (ret_i) hold_d = sram_rdata_i;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) hold_q <= '0;
      else      hold_q <= hold_d;
   end

   assign rvalid_o = ret_i;
   assign rdata_o  = ret_i ? sram_rdata_i : hold_q;
endmodule

// File: rtl/sram_port_arbiter.sv
// Single-port SRAM arbiter between fetch (IF) and memory (MEM) stages.
// One access per cycle; MEM has priority, but once IF has been denied
// MAX_IF_WAIT consecutive cycles it wins the next contended cycle.
// Reads return one cycle after grant; the last read word per requester is held.
//   clk, rst : clock, async active-low reset (all outputs 0 while low)
//   bus      : requester handshakes, read returns, stalls and SRAM drive
module sram_port_arbiter
   import sram_port_arbiter_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = WORD_W,
   parameter int MAX_IF_WAIT = 4
) (
   input  logic                clk,
   input  logic                rst,
   sram_port_arbiter_if.slave  bus
);
   localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_IF_WAIT);

   owner_e           owner_q, owner_d;
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

   logic if_gnt, mem_gnt, if_starved;

   // ---- grant decision ----
   // Grants are gated with rst so nothing leaks out while reset is held.
   always_comb begin
      if_starved = (wait_cnt_q == WAIT_MAX);
      mem_gnt    = rst & bus.mem_req & ~(bus.if_req & if_starved);
      if_gnt     = rst & bus.if_req & ~mem_gnt;
   end

   assign bus.if_gnt      = if_gnt;
   assign bus.mem_gnt     = mem_gnt;
   assign bus.stall_if_o  = rst & bus.if_req  & ~if_gnt;
   assign bus.stall_mem_o = rst & bus.mem_req & ~mem_gnt;

   // ---- SRAM drive ----
   always_comb begin
      bus.sram_en    = 1'b0;
      bus.sram_wen   = '0;
      bus.sram_addr  = '0;
      bus.sram_wdata = '0;
      if (if_gnt) begin
         bus.sram_en   = 1'b1;
         bus.sram_addr = bus.if_addr;
      end else if (mem_gnt) begin
         bus.sram_en   = 1'b1;
         bus.sram_addr = bus.mem_addr;
         if (bus.mem_we) begin
            bus.sram_wen   = bus.mem_sel;
            bus.sram_wdata = bus.mem_wdata;
         end
      end
   end

   // ---- owner of next cycle's read data; writes return nothing ----
   always_comb begin
      owner_d = OWNER_NONE;
      if (if_gnt)                      owner_d = OWNER_IF;
      else if (mem_gnt && !bus.mem_we) owner_d = OWNER_MEM_RD;
   end

   // ---- IF starvation counter: consecutive denied IF cycles, saturating ----
   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (!bus.if_req || if_gnt)   wait_cnt_d = '0;
      else if (!if_starved)        wait_cnt_d = wait_cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         owner_q    <= OWNER_NONE;
         wait_cnt_q <= '0;
      end else begin
         owner_q    <= owner_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   // ---- read return / hold, one slice per requester ----
   logic [NUM_REQ-1:0]             ret;
   logic [NUM_REQ-1:0]             rvalid;
   logic [NUM_REQ-1:0][DATA_W-1:0] rdata;

   assign ret[REQ_IF]  = (owner_q == OWNER_IF);
   assign ret[REQ_MEM] = (owner_q == OWNER_MEM_RD);

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_hold
      sram_port_arbiter_rdata_hold #(.DATA_W(DATA_W)) u_hold (
         .clk          (clk),
         .rst          (rst),
         .ret_i        (ret[g]),
         .sram_rdata_i (bus.sram_rdata),
         .rvalid_o     (rvalid[g]),
         .rdata_o      (rdata[g])
      );
   end

   assign bus.if_rvalid  = rvalid[REQ_IF];
   assign bus.if_rdata   = rdata[REQ_IF];
   assign bus.mem_rvalid = rvalid[REQ_MEM];
   assign bus.mem_rdata  = rdata[REQ_MEM];
endmodule

// File: tb/tb_sram_port_arbiter.sv
module tb_sram_port_arbiter;
   import sram_port_arbiter_pkg::*;

   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int MAXW = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   sram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

   sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_IF_WAIT(MAXW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   always @(posedge clk) cyc++;

   typedef struct {
      int          stamp;
      logic [31:0] data;
   } exp_t;

   exp_t        if_q[$];
   exp_t        mem_q[$];
   logic [31:0] smem[int];   // SRAM contents as written by the DUT
   logic [31:0] gold[int];   // reference memory image kept by the model
   int          wcnt;        // model: consecutive cycles IF has been refused
   logic        g_if;
   logic        s_en;
   logic [3:0]  s_wen;
   logic [31:0] s_addr, s_wdata;
   logic [31:0] last_if, last_mem;

   function automatic logic [31:0] dflt(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
   endfunction

   function automatic logic [31:0] rd_gold(input logic [31:0] a);
      return gold.exists(int'(a)) ? gold[int'(a)] : dflt(a);
   endfunction

   function automatic logic [31:0] rd_smem(input logic [31:0] a);
      return smem.exists(int'(a)) ? smem[int'(a)] : dflt(a);
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] sel);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = wd[8*b +: 8];
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic preset(input logic [31:0] a, input logic [31:0] v);
      smem[int'(a)] = v;
      gold[int'(a)] = v;
   endtask

   // ---- monitor: read returns against the scoreboard queues ----
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         last_if  = '0;
         last_mem = '0;
      end else begin
         if (bus.if_rvalid === 1'b1) begin
            if (if_q.size() == 0 || if_q[0].stamp != cyc - 1)
               chk("if_rvalid_unexpected", 32'(bus.if_rvalid), 32'd0);
            else begin
               e = if_q.pop_front();
               chk("if_rdata", bus.if_rdata, e.data);
               last_if = e.data;
            end
         end else if (if_q.size() != 0 && if_q[0].stamp == cyc - 1) begin
            chk("if_rvalid_missing", 32'(bus.if_rvalid), 32'd1);
            void'(if_q.pop_front());
         end else
            chk("if_rdata_hold", bus.if_rdata, last_if);

         if (bus.mem_rvalid === 1'b1) begin
            if (mem_q.size() == 0 || mem_q[0].stamp != cyc - 1)
               chk("mem_rvalid_unexpected", 32'(bus.mem_rvalid), 32'd0);
            else begin
               e = mem_q.pop_front();
               chk("mem_rdata", bus.mem_rdata, e.data);
               last_mem = e.data;
            end
         end else if (mem_q.size() != 0 && mem_q[0].stamp == cyc - 1) begin
            chk("mem_rvalid_missing", 32'(bus.mem_rvalid), 32'd1);
            void'(mem_q.pop_front());
         end else
            chk("mem_rdata_hold", bus.mem_rdata, last_mem);
      end
   end

   // ---- one bus cycle: drive, predict, check combinational outputs, clock SRAM ----
   // Entered and left at posedge+1.
   task automatic step(input logic ir, input logic [31:0] ia,
                       input logic mr, input logic mwe, input logic [3:0] msel,
                       input logic [31:0] ma, input logic [31:0] md,
                       input bit rst_before_edge = 1'b0);
      logic eg_if, eg_mem, e_wr;
      bus.if_req    = ir;
      bus.if_addr   = ia;
      bus.mem_req   = mr;
      bus.mem_we    = mwe;
      bus.mem_sel   = msel;
      bus.mem_addr  = ma;
      bus.mem_wdata = md;

      // MEM first, unless IF has already been refused MAXW cycles in a row
      eg_mem = mr && !(ir && wcnt == MAXW);
      eg_if  = ir && !eg_mem;
      e_wr   = eg_mem && mwe;
      if (eg_if)           if_q.push_back('{cyc, rd_gold(ia)});
      if (eg_mem && !mwe)  mem_q.push_back('{cyc, rd_gold(ma)});
      if (e_wr)            gold[int'(ma)] = merge(rd_gold(ma), md, msel);

      @(negedge clk);
      chk("if_gnt",      32'(bus.if_gnt),      32'(eg_if));
      chk("mem_gnt",     32'(bus.mem_gnt),     32'(eg_mem));
      chk("stall_if",    32'(bus.stall_if_o),  32'(ir && !eg_if));
      chk("stall_mem",   32'(bus.stall_mem_o), 32'(mr && !eg_mem));
      chk("sram_en",     32'(bus.sram_en),     32'(eg_if || eg_mem));
      chk("sram_wen",    32'(bus.sram_wen),    e_wr ? 32'(msel) : 32'd0);
      chk("sram_addr",   bus.sram_addr,        eg_if ? ia : (eg_mem ? ma : 32'd0));
      if (!(eg_mem && !mwe))
         chk("sram_wdata", bus.sram_wdata,     e_wr ? md : 32'd0);
      g_if    = bus.if_gnt;
      s_en    = bus.sram_en;
      s_wen   = bus.sram_wen;
      s_addr  = bus.sram_addr;
      s_wdata = bus.sram_wdata;

      if (rst_before_edge) begin
         #1 rst = 1'b0;
         if_q.delete();
         mem_q.delete();
         wcnt = 0;
         @(posedge clk); #1;
         return;
      end

      @(posedge clk); #1;
      // SRAM model: registered read, byte-masked write
      if (s_en) begin
         if (s_wen == 4'd0) bus.sram_rdata = rd_smem(s_addr);
         else               smem[int'(s_addr)] = merge(rd_smem(s_addr), s_wdata, s_wen);
      end
      wcnt = (!ir || eg_if) ? 0 : ((wcnt < MAXW) ? wcnt + 1 : MAXW);
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
   endtask

   // Hold reset with both requests active; every output must stay 0.
   task automatic do_reset(input int n);
      rst = 1'b0;
      if_q.delete();
      mem_q.delete();
      wcnt = 0;
      bus.if_req    = 1'b1;
      bus.if_addr   = 32'h44;
      bus.mem_req   = 1'b1;
      bus.mem_we    = 1'b1;
      bus.mem_sel   = 4'hF;
      bus.mem_addr  = 32'h88;
      bus.mem_wdata = 32'hFFFF_FFFF;
      repeat (n) begin
         @(negedge clk);
         chk("rst_if_gnt",     32'(bus.if_gnt),      32'd0);
         chk("rst_mem_gnt",    32'(bus.mem_gnt),     32'd0);
         chk("rst_if_rvalid",  32'(bus.if_rvalid),   32'd0);
         chk("rst_mem_rvalid", 32'(bus.mem_rvalid),  32'd0);
         chk("rst_if_rdata",   bus.if_rdata,         32'd0);
         chk("rst_mem_rdata",  bus.mem_rdata,        32'd0);
         chk("rst_stall_if",   32'(bus.stall_if_o),  32'd0);
         chk("rst_stall_mem",  32'(bus.stall_mem_o), 32'd0);
         chk("rst_sram_en",    32'(bus.sram_en),     32'd0);
         chk("rst_sram_wen",   32'(bus.sram_wen),    32'd0);
         chk("rst_sram_addr",  bus.sram_addr,        32'd0);
         chk("rst_sram_wdata", bus.sram_wdata,       32'd0);
         @(posedge clk); #1;
      end
      bus.if_req  = 1'b0;
      bus.mem_req = 1'b0;
      bus.mem_we  = 1'b0;
      rst = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic        ir, mr, mwe;
      logic [31:0] ia, ma;
      bus.if_req     = 1'b0;
      bus.if_addr    = '0;
      bus.mem_req    = 1'b0;
      bus.mem_we     = 1'b0;
      bus.mem_sel    = '0;
      bus.mem_addr   = '0;
      bus.mem_wdata  = '0;
      bus.sram_rdata = '0;
      wcnt = 0;

      do_reset(3);

      // fetch streaming, one per cycle
      preset(32'h0, 32'h11);
      preset(32'h4, 32'h22);
      preset(32'h8, 32'h33);
      step(1'b1, 32'h0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
      step(1'b1, 32'h4, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
      step(1'b1, 32'h8, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
      idle(2);

      // contention: MEM read first, then IF
      preset(32'h100, 32'hCAFE0001);
      step(1'b1, 32'hC, 1'b1, 1'b0, 4'd0, 32'h100, 32'd0);
      step(1'b1, 32'hC, 1'b0, 1'b0, 4'd0, 32'd0,   32'd0);
      idle(1);

      // byte-masked write, no return; then read it back
      step(1'b0, 32'd0, 1'b1, 1'b1, 4'b0011, 32'h200, 32'hDEADBEEF);
      idle(1);
      step(1'b0, 32'd0, 1'b1, 1'b0, 4'd0, 32'h200, 32'd0);
      idle(1);

      // starvation bound: IF wins on the 5th contended cycle
      for (int i = 0; i < 6; i++) begin
         step(1'b1, 32'h40, 1'b1, 1'b0, 4'd0, 32'h80 + 32'(4 * i), 32'd0);
         chk("starve_if_gnt", 32'(g_if), (i == 4) ? 32'd1 : 32'd0);
      end
      idle(2);

      // reset with an IF read outstanding
      step(1'b1, 32'h20, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
      do_reset(2);
      idle(2);

      // hold of last fetch data across idle cycles
      preset(32'h300, 32'h55AA);
      step(1'b1, 32'h300, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
      idle(4);

      // randomized traffic with occasional reset
      for (int n = 0; n < 500; n++) begin
         if ($urandom_range(0, 149) == 0) do_reset(1 + $urandom_range(0, 2));
         ir  = ($urandom_range(0, 2) != 0);
         mr  = ($urandom_range(0, 2) != 0);
         mwe = ($urandom_range(0, 2) == 0);
         ia  = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
         ma  = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
         step(ir, ia, mr, mwe, 4'($urandom_range(0, 15)), ma, $urandom);
      end
      idle(3);
      chk("if_queue_drained",  32'(if_q.size()),  32'd0);
      chk("mem_queue_drained", 32'(mem_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
